// File: rtl/regfile_exec_pkg.sv
// Shared definitions for the register-file execute/write-back sequencer:
// FSM states, opcode values and flag bit positions.
package regfile_exec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_MOVI = 4'd9;

    // flags vector is {N,Z,C,V}
    localparam int unsigned FLAG_V = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_N = 3;

    // Opcodes above MOVI are undefined and complete without a write.
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_MOVI);
    endfunction

endpackage

// File: rtl/regfile_exec_mul.sv
// Iterative shift-add multiplier returning the low DATA_W bits of the
// unsigned product. The first MUL_STEP bits are retired on the start edge,
// so done rises after DATA_W/MUL_STEP clocked steps in total.
module regfile_exec_mul #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned MUL_STEP = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int unsigned ITERS = DATA_W / MUL_STEP;
    localparam int unsigned CNT_W = $clog2(ITERS) + 1;

    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [CNT_W-1:0]  cnt;
    logic              run;

    // Sum of the multiplicand shifted by each set bit of one multiplier digit.
    function automatic logic [DATA_W-1:0] partial(input logic [DATA_W-1:0] m,
                                                  input logic [MUL_STEP-1:0] bits);
        logic [DATA_W-1:0] p;
        p = '0;
        for (int unsigned i = 0; i < MUL_STEP; i++) begin
            if (bits[i]) p = p + (m << i);
        end
        return p;
    endfunction

    // Load retires the first digit; each later cycle retires one more.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            run    <= 1'b0;
        end else if (start) begin
            acc    <= partial(a, b[MUL_STEP-1:0]);
            mcand  <= a << MUL_STEP;
            mplier <= b >> MUL_STEP;
            cnt    <= CNT_W'(ITERS - 1);
            run    <= 1'b1;
        end else if (run) begin
            if (cnt != '0) begin
                acc    <= acc + partial(mcand, mplier[MUL_STEP-1:0]);
                mcand  <= mcand << MUL_STEP;
                mplier <= mplier >> MUL_STEP;
                cnt    <= cnt - 1'b1;
            end else begin
                run <= 1'b0;
            end
        end
    end

    assign done    = run && (cnt == '0);
    assign product = acc;

endmodule

// File: rtl/regfile_exec_ctrl.sv
// Execute/write-back sequencer in front of a 2-read/1-write register file.
// IDLE -> READ (operand fetch) -> EXEC (ALU or iterative multiply) -> WRITE.
module regfile_exec_ctrl
    import regfile_exec_pkg::*;
#(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned MUL_STEP = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        opcode,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] in_imm,
    output logic [ADDR_W-1:0] R_Addr,
    output logic [ADDR_W-1:0] S_Addr,
    input  logic [DATA_W-1:0] R,
    input  logic [DATA_W-1:0] S,
    output logic              W_En,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [DATA_W-1:0] WR,
    output logic              busy,
    output logic              done,
    output logic [3:0]        flags,
    output logic              illegal
);

    localparam int unsigned SH_W = $clog2(DATA_W);
    localparam int unsigned MSB  = DATA_W - 1;

    state_t            state, state_d;
    logic [3:0]        opcode_q;
    logic [ADDR_W-1:0] dst_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] op_a, op_b;

    logic              mul_start, mul_done;
    logic [DATA_W-1:0] mul_product;
    logic              exec_fin, legal;
    logic [SH_W-1:0]   sh_amt;
    logic [DATA_W:0]   sum_w;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c, alu_v;
    logic [3:0]        flags_d;

    assign busy      = (state != IDLE);
    assign legal     = op_is_legal(opcode_q);
    assign sh_amt    = op_b[SH_W-1:0];
    assign mul_start = (state == READ) && (opcode_q == OP_MUL);
    assign exec_fin  = (opcode_q == OP_MUL) ? mul_done : 1'b1;

    // Multiplier loads straight from the read ports in READ, the same
    // values op_a/op_b capture, so its first step overlaps the fetch edge.
    regfile_exec_mul #(
        .DATA_W   (DATA_W),
        .MUL_STEP (MUL_STEP)
    ) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (mul_start),
        .a       (R),
        .b       (S),
        .done    (mul_done),
        .product (mul_product)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (in_valid && in_ready) state_d = READ;
            READ:    state_d = EXEC;
            EXEC:    if (exec_fin) state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ALU result and {N,Z,C,V} for the latched opcode.
    always_comb begin
        sum_w   = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (opcode_q)
            OP_ADD: begin
                sum_w   = {1'b0, op_a} + {1'b0, op_b};
                alu_res = sum_w[DATA_W-1:0];
                alu_c   = sum_w[DATA_W];
                alu_v   = (op_a[MSB] == op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
            end
            OP_SUB: begin
                alu_res = op_a - op_b;
                alu_c   = (op_a < op_b);
                alu_v   = (op_a[MSB] != op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
            end
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SLL:  alu_res = op_a << sh_amt;
            OP_SRL:  alu_res = op_a >> sh_amt;
            OP_SRA:  alu_res = DATA_W'($signed(op_a) >>> sh_amt);
            OP_MUL:  alu_res = mul_product;
            OP_MOVI: alu_res = imm_q;
            default: alu_res = '0;
        endcase
        flags_d         = '0;
        flags_d[FLAG_N] = alu_res[MSB];
        flags_d[FLAG_Z] = (alu_res == '0);
        flags_d[FLAG_C] = alu_c;
        flags_d[FLAG_V] = alu_v;
    end

    // Registered datapath: accept latch, operand capture, write-back and status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_ready <= 1'b0;
            opcode_q <= '0;
            dst_q    <= '0;
            imm_q    <= '0;
            R_Addr   <= '0;
            S_Addr   <= '0;
            op_a     <= '0;
            op_b     <= '0;
            W_En     <= 1'b0;
            W_Addr   <= '0;
            WR       <= '0;
            done     <= 1'b0;
            illegal  <= 1'b0;
            flags    <= '0;
        end else begin
            in_ready <= (state_d == IDLE);
            W_En     <= 1'b0;
            done     <= 1'b0;
            illegal  <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        opcode_q <= opcode;
                        dst_q    <= dst_addr;
                        imm_q    <= in_imm;
                        R_Addr   <= a_addr;
                        S_Addr   <= b_addr;
                    end
                end
                READ: begin
                    op_a <= R;
                    op_b <= S;
                end
                EXEC: begin
                    if (exec_fin) begin
                        done <= 1'b1;
                        if (legal) begin
                            W_En   <= 1'b1;
                            W_Addr <= dst_q;
                            WR     <= alu_res;
                            flags  <= flags_d;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_exec_ctrl.sv
// Bench for regfile_exec_ctrl: a behavioural register file is attached to
// the read/write ports, a cycle-level model predicts every output, and
// directed programs pin results, flags and latencies with literal values.
module tb_regfile_exec_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  opcode = '0;
    logic [4:0]  dst_addr = '0, a_addr = '0, b_addr = '0;
    logic [63:0] in_imm = '0;
    logic [4:0]  R_Addr, S_Addr, W_Addr;
    logic [63:0] R, S, WR;
    logic        W_En, busy, done, illegal;
    logic [3:0]  flags;

    logic [63:0] rf [32];

    int checks = 0;
    int failures = 0;

    regfile_exec_ctrl #(
        .DATA_W   (64),
        .ADDR_W   (5),
        .MUL_STEP (1)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .opcode   (opcode),
        .dst_addr (dst_addr),
        .a_addr   (a_addr),
        .b_addr   (b_addr),
        .in_imm   (in_imm),
        .R_Addr   (R_Addr),
        .S_Addr   (S_Addr),
        .R        (R),
        .S        (S),
        .W_En     (W_En),
        .W_Addr   (W_Addr),
        .WR       (WR),
        .busy     (busy),
        .done     (done),
        .flags    (flags),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    // Register file stand-in: combinational reads, write on the clock edge.
    assign R = rf[R_Addr];
    assign S = rf[S_Addr];
    always @(posedge clk) if (W_En) rf[W_Addr] <= WR;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural result of one instruction, from plain arithmetic.
    task automatic model_exec(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] imm, output logic [63:0] r,
                              output logic [3:0] fl, output logic ok);
        logic [64:0]        w;
        logic signed [65:0] ss;
        logic               c, v;
        int unsigned        sh;
        c = 1'b0; v = 1'b0; ok = 1'b1; r = '0; w = '0; ss = '0;
        sh = 32'(b[5:0]);
        case (op)
            4'd0: begin
                w  = {1'b0, a} + {1'b0, b};
                r  = w[63:0];
                c  = w[64];
                ss = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
                v  = (ss != $signed({{2{r[63]}}, r}));
            end
            4'd1: begin
                r  = a - b;
                c  = (a < b);
                ss = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
                v  = (ss != $signed({{2{r[63]}}, r}));
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << sh;
            4'd6: r = a >> sh;
            4'd7: r = $signed(a) >>> sh;
            4'd8: r = a * b;
            4'd9: r = imm;
            default: ok = 1'b0;
        endcase
        fl = {r[63], (r == 64'd0), c, v};
    endtask

    // Cycle model: edges remaining until the write edge of the current op.
    logic [63:0] exp_rf [32];
    logic        m_ready, m_busy, m_legal;
    int          m_left;
    logic [3:0]  m_flags, m_fl_new;
    logic [63:0] m_res;
    logic [4:0]  m_dst;

    initial begin : model
        for (int i = 0; i < 32; i++) exp_rf[i] = '0;
        m_ready = 1'b0; m_busy = 1'b0; m_legal = 1'b0; m_left = 0;
        m_flags = '0; m_fl_new = '0; m_res = '0; m_dst = '0;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_ready = 1'b0; m_busy = 1'b0; m_left = 0; m_flags = '0;
            end else if (m_busy) begin
                m_left--;
                if (m_left == 1 && m_legal) m_flags = m_fl_new;
                if (m_left == 0) begin
                    m_busy  = 1'b0;
                    m_ready = 1'b1;
                    if (m_legal) exp_rf[m_dst] = m_res;
                end
            end else if (!m_ready) begin
                m_ready = 1'b1;
            end else if (in_valid) begin
                model_exec(opcode, exp_rf[a_addr], exp_rf[b_addr], in_imm, m_res, m_fl_new, m_legal);
                m_dst   = dst_addr;
                m_left  = (opcode == 4'd8) ? 66 : 3;
                m_busy  = 1'b1;
                m_ready = 1'b0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin : compare
        logic exp_w;
        forever begin
            @(negedge clk);
            exp_w = m_busy && (m_left == 1);
            chk("in_ready", 64'(in_ready), 64'(m_ready));
            chk("busy",     64'(busy),     64'(m_busy));
            chk("W_En",     64'(W_En),     64'(exp_w && m_legal));
            chk("done",     64'(done),     64'(exp_w));
            chk("illegal",  64'(illegal),  64'(exp_w && !m_legal));
            chk("flags",    64'(flags),    64'(m_flags));
            if (exp_w && m_legal) begin
                chk("W_Addr", 64'(W_Addr), 64'(m_dst));
                chk("WR",     WR,          m_res);
            end
        end
    end

    int   lat;
    logic ill_seen, wen_seen, rdy_seen;

    // Offers one instruction and follows it to done (or to the abort point).
    task automatic issue(input logic [3:0] op, input logic [4:0] d, input logic [4:0] a,
                         input logic [4:0] b, input logic [63:0] imm, input int abort_at,
                         output int l, output logic ill, output logic wen, output logic rdy);
        int n;
        l = 0; ill = 1'b0; wen = 1'b0; rdy = 1'b0;
        @(negedge clk);
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            chk("accept_timeout", 64'd0, 64'd1);
            return;
        end
        opcode = op; dst_addr = d; a_addr = a; b_addr = b; in_imm = imm;
        in_valid = 1'b1;
        @(posedge clk);
        for (n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (n == 1) in_valid = 1'b0;
            if (abort_at != 0 && n == abort_at) begin
                #2 reset_n = 1'b0;
                return;
            end
            if (in_ready) rdy = 1'b1;
            if (W_En) wen = 1'b1;
            if (done) begin
                l   = n;
                ill = illegal;
                break;
            end
        end
        if (l == 0) chk("done_timeout", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    initial begin : stimulus
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 64'(in_ready), 64'd1);

        issue(4'd9, 5'd1, 5'd0, 5'd0, 64'd5, 0, lat, ill_seen, wen_seen, rdy_seen);
        chk("movi_latency", 64'(lat), 64'd3);
        chk("r1", rf[1], 64'd5);
        issue(4'd9, 5'd2, 5'd0, 5'd0, 64'd3, 0, lat, ill_seen, wen_seen, rdy_seen);
        chk("r2", rf[2], 64'd3);

        issue(4'd0, 5'd3, 5'd1, 5'd2, 64'd0, 0, lat, ill_seen, wen_seen, rdy_seen);
        chk("add_latency", 64'(lat), 64'd3);
        chk("add_r3", rf[3], 64'd8);
        chk("add_flags", 64'(flags), 64'b0000);

        issue(4'd1, 5'd4, 5'd2, 5'd1, 64'd0, 0, lat, ill_seen, wen_seen, rdy_seen);
        chk("sub_r4", rf[4], 64'hFFFF_FFFF_FFFF_FFFE);
        chk("sub_flags", 64'(flags), 64'b1010);

        issue(4'd9, 5'd13, 5'd0, 5'd0, 64'h7FFF_FFFF_FFFF_FFFF, 0, lat, ill_seen, wen_seen, rdy_seen);
        issue(4'd9, 5'd14, 5'd0, 5'd0, 64'd1, 0, lat, ill_seen, wen_seen, rdy_seen);
        issue(4'd0, 5'd15, 5'd13, 5'd14, 64'd0, 0, lat, ill_seen, wen_seen, rdy_seen);
        chk("ovf_r15", rf[15], 64'h8000_0000_0000_0000);
        chk("ovf_flags", 64'(flags), 64'b1001);

        issue(4'd9, 5'd5, 5'd0, 5'd0, 64'h0000_0001_0000_0001, 0, lat, ill_seen, wen_seen, rdy_seen);
        issue(4'd9, 5'd6, 5'd0, 5'd0, 64'h0000_0000_FFFF_FFFF, 0, lat, ill_seen, wen_seen, rdy_seen);
        issue(4'd8, 5'd7, 5'd5, 5'd6, 64'd0, 0, lat, ill_seen, wen_seen, rdy_seen);
        chk("mul_latency", 64'(lat), 64'd66);
        chk("mul_ready_low", 64'(rdy_seen), 64'd0);
        chk("mul_r7", rf[7], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("mul_flags", 64'(flags), 64'b1000);

        issue(4'd9, 5'd8, 5'd0, 5'd0, 64'h8000_0000_0000_0000, 0, lat, ill_seen, wen_seen, rdy_seen);
        issue(4'd9, 5'd9, 5'd0, 5'd0, 64'd63, 0, lat, ill_seen, wen_seen, rdy_seen);
        issue(4'd7, 5'd10, 5'd8, 5'd9, 64'd0, 0, lat, ill_seen, wen_seen, rdy_seen);
        chk("sra_r10", rf[10], 64'hFFFF_FFFF_FFFF_FFFF);

        issue(4'd12, 5'd3, 5'd1, 5'd2, 64'd0, 0, lat, ill_seen, wen_seen, rdy_seen);
        chk("illegal_latency", 64'(lat), 64'd3);
        chk("illegal_pulse", 64'(ill_seen), 64'd1);
        chk("illegal_no_wen", 64'(wen_seen), 64'd0);
        chk("illegal_r3_kept", rf[3], 64'd8);
        chk("illegal_flags_kept", 64'(flags), 64'b1000);

        issue(4'd9, 5'd11, 5'd0, 5'd0, 64'd64, 0, lat, ill_seen, wen_seen, rdy_seen);
        issue(4'd5, 5'd12, 5'd1, 5'd11, 64'd0, 0, lat, ill_seen, wen_seen, rdy_seen);
        chk("sll64_r12", rf[12], 64'd5);

        issue(4'd1, 5'd17, 5'd1, 5'd1, 64'd0, 0, lat, ill_seen, wen_seen, rdy_seen);
        chk("sub_zero_r17", rf[17], 64'd0);
        chk("sub_zero_flags", 64'(flags), 64'b0100);

        issue(4'd9, 5'd0, 5'd0, 5'd0, 64'd7, 0, lat, ill_seen, wen_seen, rdy_seen);
        chk("r0_write", rf[0], 64'd7);

        // Abort a multiply in its 20th EXEC cycle.
        issue(4'd8, 5'd3, 5'd5, 5'd6, 64'd0, 21, lat, ill_seen, wen_seen, rdy_seen);
        @(negedge clk);
        chk("abort_wen", 64'(W_En), 64'd0);
        chk("abort_ready", 64'(in_ready), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_flags", 64'(flags), 64'd0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("abort_ready_release", 64'(in_ready), 64'd1);
        chk("abort_r3_kept", rf[3], 64'd8);

        issue(4'd0, 5'd16, 5'd1, 5'd2, 64'd0, 0, lat, ill_seen, wen_seen, rdy_seen);
        chk("post_abort_latency", 64'(lat), 64'd3);
        chk("post_abort_r16", rf[16], 64'd8);
        chk("post_abort_flags", 64'(flags), 64'b0000);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_exec_ctrl.md
Name: regfile_exec_ctrl

Overview:
Multi-cycle execute/write-back sequencer that sits in front of the 64-bit, 32-entry, 2-read/1-write register file.
- Accepts one instruction at a time over a valid/ready handshake.
- Drives the register file read addresses and captures the R/S operands.
- Executes a 64-bit ALU or iterative-multiply operation.
- Writes the result back through the file's W_En/W_Addr/WR port and reports status flags.

Parameters:
DATA_W, 64, operand/result width (must match register file)
ADDR_W, 5, register address width
MUL_STEP, 1, multiplier bits retired per EXEC cycle; legal values 1, 2, 4; multiply takes DATA_W/MUL_STEP cycles

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  instruction offered
in_ready  output  1  block can accept; registered; high only in IDLE
opcode  input  4  operation, sampled on accept
dst_addr  input  ADDR_W  destination register
a_addr  input  ADDR_W  source A register
b_addr  input  ADDR_W  source B register
in_imm  input  DATA_W  immediate for MOVI
R_Addr  output  ADDR_W  register file read port R address
S_Addr  output  ADDR_W  register file read port S address
R  input  DATA_W  register file read data R (combinational)
S  input  DATA_W  register file read data S (combinational)
W_En  output  1  register file write enable
W_Addr  output  ADDR_W  register file write address
WR  output  DATA_W  register file write data
busy  output  1  high in READ/EXEC/WRITE
done  output  1  one-cycle pulse in the WRITE cycle
flags  output  4  {N,Z,C,V}, updated on completion
illegal  output  1  one-cycle pulse with done for an undefined opcode

Behaviour:
- Reset, asynchronous: state=IDLE; every output and internal register is 0, including in_ready. in_ready rises on the first clk edge after reset_n deasserts.
- Accept: in_valid&in_ready at a posedge.
  - Latch opcode, dst_addr and in_imm.
  - Load R_Addr<=a_addr and S_Addr<=b_addr.
  - in_ready<=0; go to READ.
- READ (1 cycle): capture opA<=R and opB<=S at the end of the cycle; go to EXEC.
- EXEC, single-cycle ops (1 cycle): compute the result; go to WRITE.
- EXEC, MUL: initialise on entry, then iterate MUL_STEP bits per cycle for DATA_W/MUL_STEP cycles total; go to WRITE.
- WRITE (1 cycle): W_En=1, W_Addr=dst, WR=result, done=1; flags update. On exit: W_En=0, in_ready<=1, go to IDLE.
- Latency, accept edge to write edge: 3 cycles for single-cycle ops; 2+DATA_W/MUL_STEP cycles for MUL (66 at default).
- Throughput: the next accept is no earlier than the edge after WRITE.
- RAW hazards: none. A write commits before any later READ.
- Opcodes:
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA: shift amount = opB[5:0]
  - 8 MUL: low DATA_W bits of the unsigned product
  - 9 MOVI: result = in_imm; operands ignored
  - 10-15: illegal
- Flags:
  - N = result[63]; Z = (result==0).
  - ADD: C = carry-out. SUB: C = borrow (A<B unsigned).
  - ADD/SUB: V = signed overflow.
  - C=V=0 for all other legal ops.
- Illegal opcode: follow the normal sequence, but W_En stays 0 in WRITE. done=1 and illegal=1; flags unchanged.
- Writes to register 0 are allowed (the file has no hardwired zero).
- W_En, W_Addr and WR are registered; W_En is 0 outside WRITE.
- in_valid while busy is ignored; the instruction must be held until accepted.
- Reset mid-operation: immediate IDLE, no write, flags cleared.

Decomposition:
- Shared package regfile_exec_pkg holds:
  - opcode constants OP_ADD..OP_MOVI
  - state encoding IDLE/READ/EXEC/WRITE
  - flag bit indices
- One sub-module, regfile_exec_mul: iterative shift-add multiplier with start/done, parameterised by DATA_W and MUL_STEP.
- ALU and FSM stay in the top level.

Test Plan:
- Bench ties this block to regfile64. MOVI r1=0x0000_0000_0000_0005 and MOVI r2=0x0000_0000_0000_0003, then ADD r3=r1+r2. Required: r3=8; W_En pulse 3 cycles after each accept; flags=0000.
- SUB r4=r2-r1. Required: r4=0xFFFF_FFFF_FFFF_FFFE; N=1, C=1, Z=0, V=0. ADD of 0x7FFF_FFFF_FFFF_FFFF+1. Required: V=1, N=1.
- MUL of r5=0x1_0000_0001 by r6=0xFFFF_FFFF. Required: r7=0xFFFF_FFFF_FFFF_FFFF; done exactly 66 cycles after accept; in_ready low throughout.
- SRA of 0x8000_0000_0000_0000 by 63. Required: all ones. SLL by opB=64 (shift field 0). Required: value unchanged.
- Opcode 12 with dst=r3. Required: done and illegal pulse together; W_En never asserts; r3 retains 8.
- reset_n pulled low during MUL EXEC cycle 20. Required: W_En stays 0 and the destination register is unchanged. in_ready returns 1 one edge after release, then ADD completes normally.
